mem_arbiter: RTL and testbench

Two-requester arbiter sharing one word-addressed memory port between the core's instruction-fetch path and its load/store path. It sits between the CPU core and the SoC memory. It serialises accesses and holds one transaction outstanding at a time. It tolerates variable memory latency through a req/ack handshake and aborts accesses that are never acknowledged.

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one word-addressed memory port, one access outstanding.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed load/store priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [3:0]        ls_we,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned   CW        = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       wait_q, wait_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic                ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic                pick_ls, done, done_err;
  logic [DATA_W-1:0]   done_data;
`ifdef MEM_ARB_RR_EN
  logic                last_if_q, last_if_d;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    done_data   = '0;
`ifdef MEM_ARB_RR_EN
    last_if_d   = last_if_q;
    // On a tie, load/store wins only if fetch owned the previous grant.
    pick_ls     = ls_req && (!if_req || last_if_q);
`else
    pick_ls     = ls_req;
`endif

    case (state_q)
      IDLE: begin
        if (ls_req || if_req) begin
          ls_gnt    = pick_ls;
          if_gnt    = !pick_ls;
          mem_req_d = 1'b1;
          wait_d    = '0;
`ifdef MEM_ARB_RR_EN
          last_if_d = !pick_ls;
`endif
          if (pick_ls) begin
            mem_addr_d  = ls_addr;
            mem_we_d    = ls_we;
            mem_wdata_d = ls_wdata;
            state_d     = BUSY_LS;
          end else begin
            mem_addr_d  = if_addr;
            mem_we_d    = '0;
            mem_wdata_d = '0;
            state_d     = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack) begin
          done      = 1'b1;
          done_data = (mem_we_q == '0) ? mem_rdata : '0;
        end else if (wait_q == WAIT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
        if (done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_IF) begin
            if_rvalid_d = 1'b1;
            if_err_d    = done_err;
            if_rdata_d  = done_data;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_err_d    = done_err;
            ls_rdata_d  = done_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_if_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_if_q   <= last_if_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grants, memory-port
// activity and completions from grant cycle and planned ack delay.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_gnt, ls_rvalid, ls_err;
  logic [AW-1:0] ls_addr;
  logic [3:0]    ls_we;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_req, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction model: one access lives from gnt_at to done_at (completion cycle).
  int            t;
  int            gnt_at = -10, done_at = -10, ack_at = -1;
  bit            owner_ls, timed_out, just_reset;
  bit            if_pend, ls_pend, if_out, ls_out;
  bit            last_if = 1'b1;
  logic [AW-1:0] c_addr;
  logic [3:0]    c_we;
  logic [DW-1:0] c_wdata, exp_rdata;

  function automatic bit busy(input int c);
    return (c > gnt_at) && (c < done_at);
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom % 10);
    if (r < 6) return int'($urandom % 3);
    if (r == 6) return int'(MW) - 1;
    if (r == 7) return int'(MW);
    if (r == 8) return int'(MW) - 2;
    return int'($urandom % 8);
  endfunction

  initial begin
    bit idle, tie_ls, g_ls, g_if;
    int k;
    rst = 1'b1; if_req = 0; ls_req = 0; if_addr = '0; ls_addr = '0; ls_we = '0;
    ls_wdata = '0; mem_ack = 0; mem_rdata = '0;
    if_pend = 0; ls_pend = 0; if_out = 0; ls_out = 0; just_reset = 0; timed_out = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_rvalid", 64'({if_rvalid, ls_rvalid, if_err, ls_err}), 64'd0);
    check("rst_rdata", 64'({if_rdata, ls_rdata}), 64'd0);
    check("rst_gnt", 64'({if_gnt, ls_gnt}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (t = 0; t < 3000; t++) begin
      // drive this cycle's inputs
      rst = (busy(t) && t > gnt_at + 1 && ($urandom % 60) == 0);
      if (!if_pend && !if_out && ($urandom % 3) == 0) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!ls_pend && !ls_out && ($urandom % 3) == 0) begin
        ls_pend = 1; ls_addr = $urandom; ls_wdata = $urandom;
        ls_we = ($urandom % 2 == 0) ? 4'($urandom) : 4'd0;
      end
      if_req = if_pend;
      ls_req = ls_pend;
      mem_rdata = $urandom;
      if (busy(t)) begin
        mem_ack = (t == ack_at);
        if (mem_ack) exp_rdata = (c_we == 4'd0) ? mem_rdata : '0;
      end else begin
        mem_ack = (timed_out && t == done_at) || ($urandom % 4 == 0);
      end

      @(negedge clk);
      idle = (t >= done_at);
`ifdef MEM_ARB_RR_EN
      tie_ls = last_if;
`else
      tie_ls = 1'b1;
`endif
      g_ls = idle && ls_pend && (!if_pend || tie_ls);
      g_if = idle && if_pend && !g_ls;
      check("if_gnt", 64'(if_gnt), 64'(g_if));
      check("ls_gnt", 64'(ls_gnt), 64'(g_ls));
      check("if_rvalid", 64'(if_rvalid), 64'(t == done_at && !owner_ls));
      check("ls_rvalid", 64'(ls_rvalid), 64'(t == done_at && owner_ls));
      check("mem_req", 64'(mem_req), 64'(busy(t)));
      if (busy(t)) begin
        check("mem_addr", 64'(mem_addr), 64'(c_addr));
        check("mem_we", 64'(mem_we), 64'(c_we));
        check("mem_wdata", 64'(mem_wdata), 64'(c_wdata));
      end
      if (t == done_at) begin
        check("rdata", 64'(owner_ls ? ls_rdata : if_rdata), 64'(exp_rdata));
        check("err", 64'(owner_ls ? ls_err : if_err), 64'(timed_out));
      end
      if (just_reset) begin
        check("post_rst_mem", 64'({mem_addr, mem_we}), 64'd0);
        check("post_rst_wdata", 64'(mem_wdata), 64'd0);
        check("post_rst_out", 64'({if_rvalid, ls_rvalid, if_err, ls_err}), 64'd0);
        check("post_rst_rdata", 64'({if_rdata, ls_rdata}), 64'd0);
        just_reset = 0;
      end

      // advance the model past this clock edge
      if (rst) begin
        if_out = 0; ls_out = 0; gnt_at = -10; done_at = t; timed_out = 0;
        last_if = 1'b1; just_reset = 1;
      end else begin
        if (t == done_at) begin
          if (owner_ls) ls_out = 0; else if_out = 0;
        end
        if (g_ls || g_if) begin
          owner_ls = g_ls;
          last_if  = g_if;
          gnt_at   = t;
          if (g_ls) begin
            c_addr = ls_addr; c_we = ls_we; c_wdata = ls_wdata; ls_pend = 0; ls_out = 1;
          end else begin
            c_addr = if_addr; c_we = '0; c_wdata = '0; if_pend = 0; if_out = 1;
          end
          k = pick_delay();
          if (k < int'(MW)) begin
            timed_out = 0; ack_at = t + 1 + k; done_at = t + 2 + k;
          end else begin
            timed_out = 1; ack_at = -1; done_at = t + 1 + int'(MW); exp_rdata = '0;
          end
        end
      end
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
